debounce_array: RTL

- Multi-channel debouncer for board buttons and switches, one instance per input bank, between pad inputs and user logic.
- Generalises the single-channel debouncer:
  - N channels, each with its own idle level.
  - Input synchroniser.
  - One-cycle press/release pulses.
  - Auto-repeat pulses while a channel is held.
- A shared microsecond/millisecond prescaler keeps per-channel counters narrow.

---
 rtl/debounce_array_pkg.sv | 28 ++
 rtl/debounce_channel.sv | 123 ++++++++++++
 rtl/debounce_array.sv | 95 +++++++++
 3 files changed

// File: rtl/debounce_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_array_pkg
// Description : Shared width helper and auto-repeat state encoding for the
//               multi-channel debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_array_pkg;

  // Auto-repeat state encoding, explicit 2-bit width.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RATE  = 2'd2
  } rep_state_t;

  // Number of bits needed to hold the value; never less than one bit.
  function automatic int get_width(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage : debounce_array_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debounced channel: settle counter driven by the shared
//               us tick, press/release pulses and ms-based auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import debounce_array_pkg::*;
#(
  parameter logic INIT         = 1'b0,
  parameter int   JITTER_MAX   = 10000,
  parameter int   REPEAT_DELAY = 500,
  parameter int   REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  input  logic us_tick,
  input  logic ms_tick,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W = get_width(JITTER_MAX - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(JITTER_MAX - 1);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W   = get_width(HOLD_MAX);
  // With repeat disabled DELAY_LAST is never compared, so its value is moot.
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

  logic [CNT_W-1:0]  settle_cnt;
  logic              pressed;
  rep_state_t        state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              repeat_next;

  assign pressed = (level != INIT);

  // Settle counter: any cycle matching the current level wipes progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      level         <= INIT;
      settle_cnt    <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync == level) begin
        settle_cnt <= '0;
      end else if (us_tick && (settle_cnt == SETTLE_LAST)) begin
        level      <= sync;
        settle_cnt <= '0;
        if (sync != INIT) press_pulse   <= 1'b1;
        else              release_pulse <= 1'b1;
      end else if (us_tick) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
    end
  end

  // Repeat state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      repeat_pulse <= repeat_next;
    end
  end

  // Repeat next-state: the press cycle itself already counts ms ticks,
  // which is why IDLE-while-pressed behaves exactly like DELAY.
  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    repeat_next = 1'b0;
    if (!REPEAT_EN || !pressed) begin
      state_next = IDLE;
      hold_next  = '0;
    end else begin
      case (state)
        IDLE, DELAY: begin
          state_next = DELAY;
          if (ms_tick) begin
            if (hold_cnt == DELAY_LAST) begin
              repeat_next = 1'b1;
              state_next  = RATE;
              hold_next   = '0;
            end else begin
              hold_next = hold_cnt + HOLD_W'(1);
            end
          end
        end
        RATE: begin
          if (ms_tick) begin
            if (hold_cnt == RATE_LAST) begin
              repeat_next = 1'b1;
              hold_next   = '0;
            end else begin
              hold_next = hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
          hold_next  = '0;
        end
      endcase
    end
  end

endmodule : debounce_channel
`default_nettype wire

// File: rtl/debounce_array.sv
`default_nettype none
// ============================================================================
// Module      : debounce_array
// Description : Multi-channel debouncer with two-flop synchronisers, a shared
//               us/ms prescaler and per-channel press/release/repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_array
  import debounce_array_pkg::*;
#(
  parameter int                  CHANNELS     = 16,
  parameter int                  CLK_FREQ     = 100,
  parameter int                  JITTER_MAX   = 10000,
  parameter int                  US_PER_MS    = 1000,
  parameter logic [CHANNELS-1:0] INIT_VALUE   = {CHANNELS{1'b0}},
  parameter int                  REPEAT_DELAY = 500,
  parameter int                  REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig_i,
  output logic [CHANNELS-1:0] sig_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] repeat_o
);

  localparam int US_W = get_width(CLK_FREQ - 1);
  localparam int MS_W = get_width(US_PER_MS - 1);
  localparam logic [US_W-1:0] US_LAST = US_W'(CLK_FREQ - 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(US_PER_MS - 1);

  if ((JITTER_MAX == 0) || (CLK_FREQ == 0)) begin : g_param_check
    $error("debounce_array: JITTER_MAX and CLK_FREQ must both be non-zero");
  end

  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync;
  logic [US_W-1:0]     us_cnt;
  logic [MS_W-1:0]     ms_cnt;
  logic                us_tick;
  logic                ms_tick;

  // Two-flop synchroniser; resets to the idle level so nothing looks pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= INIT_VALUE;
      sync      <= INIT_VALUE;
    end else begin
      sync_meta <= sig_i;
      sync      <= sync_meta;
    end
  end

  // Free-running microsecond prescaler.
  always_ff @(posedge clk) begin
    if (rst)          us_cnt <= '0;
    else if (us_tick) us_cnt <= '0;
    else              us_cnt <= us_cnt + US_W'(1);
  end

  // Millisecond prescaler, advanced only on us ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_cnt <= '0;
    end else if (us_tick) begin
      if (ms_cnt == MS_LAST) ms_cnt <= '0;
      else                   ms_cnt <= ms_cnt + MS_W'(1);
    end
  end

  assign us_tick = (us_cnt == US_LAST);
  assign ms_tick = us_tick && (ms_cnt == MS_LAST);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    debounce_channel #(
      .INIT         (INIT_VALUE[i]),
      .JITTER_MAX   (JITTER_MAX),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .sync          (sync[i]),
      .us_tick       (us_tick),
      .ms_tick       (ms_tick),
      .level         (sig_o[i]),
      .press_pulse   (press_o[i]),
      .release_pulse (release_o[i]),
      .repeat_pulse  (repeat_o[i])
    );
  end

endmodule : debounce_array
`default_nettype wire
